sprite_plotter: RTL and testbench

Drives the framebuffer plot interface of the 160x120 VGA adapter: x, y, colour and a one-cycle plot strobe per pixel. On each start request it erases the sprite at its previous origin in the background colour, then draws a masked W x H sprite at the new origin in the requested colour. It sits between the movement and firing datapaths and the single VGA adapter instance, and signals completion to the controlling FSM.

---
 rtl/sprite_plotter.sv | 156 +++++++++++++++
 tb/tb_sprite_plotter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_plotter.sv
// Plots a masked SPRITE_W x SPRITE_H sprite into the VGA adapter, one pixel per cycle,
// optionally erasing the previous sprite in the background colour first.
module sprite_plotter #(
  parameter int unsigned SPRITE_W  = 4,
  parameter int unsigned SPRITE_H  = 4,
  parameter logic [2:0]  BG_COLOUR = 3'b000,
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [7:0]                       x_in,
  input  logic [6:0]                       y_in,
  input  logic [2:0]                       colour_in,
  input  logic [SPRITE_W*SPRITE_H-1:0]     sprite_mask,
  input  logic                             erase_en,
  output logic                             busy,
  output logic                             done,
  output logic [7:0]                       x,
  output logic [6:0]                       y,
  output logic [2:0]                       colour,
  output logic                             plot
);

  localparam int unsigned N     = SPRITE_W * SPRITE_H;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned COL_W = 3;
  localparam int unsigned ROW_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERASE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic [7:0]       new_x;
  logic [6:0]       new_y;
  logic [2:0]       new_colour;
  logic [N-1:0]     new_mask;

  logic [7:0]       prev_x;
  logic [6:0]       prev_y;
  logic [N-1:0]     prev_mask;
  logic             prev_valid;

  logic [7:0]       org_x;
  logic [6:0]       org_y;
  logic [N-1:0]     pix_mask;
  logic [2:0]       pix_colour;
  logic [8:0]       sum_x;
  logic [7:0]       sum_y;
  logic             pix_plot;
  logic             last_pix;

  // Current pixel address and visibility; erase uses the previous sprite's origin and mask.
  always_comb begin
    org_x      = new_x;
    org_y      = new_y;
    pix_mask   = new_mask;
    pix_colour = new_colour;
    if (state == S_ERASE) begin
      org_x      = prev_x;
      org_y      = prev_y;
      pix_mask   = prev_mask;
      pix_colour = BG_COLOUR;
    end
    sum_x    = 9'(org_x) + 9'(col);
    sum_y    = 8'(org_y) + 8'(row);
    pix_plot = pix_mask[cnt] && (32'(sum_x) < SCREEN_W) && (32'(sum_y) < SCREEN_H);
  end

  assign last_pix = (cnt == CNT_W'(N - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      col        <= '0;
      row        <= '0;
      new_x      <= '0;
      new_y      <= '0;
      new_colour <= '0;
      new_mask   <= '0;
      prev_x     <= '0;
      prev_y     <= '0;
      prev_mask  <= '0;
      prev_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
    end else begin
      done <= 1'b0;
      plot <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            new_x      <= x_in;
            new_y      <= y_in;
            new_colour <= colour_in;
            new_mask   <= sprite_mask;
            cnt        <= '0;
            col        <= '0;
            row        <= '0;
            busy       <= 1'b1;
            state      <= (erase_en && prev_valid) ? S_ERASE : S_DRAW;
          end
        end

        S_ERASE, S_DRAW: begin
          plot   <= pix_plot;
          x      <= sum_x[7:0];
          y      <= sum_y[6:0];
          colour <= pix_colour;
          if (last_pix) begin
            cnt   <= '0;
            col   <= '0;
            row   <= '0;
            state <= (state == S_ERASE) ? S_DRAW : S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            // Raster order: wrap the column and step the row at the sprite's right edge.
            if (col == COL_W'(SPRITE_W - 1)) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end

        S_DONE: begin
          done       <= 1'b1;
          prev_x     <= new_x;
          prev_y     <= new_y;
          prev_mask  <= new_mask;
          prev_valid <= 1'b1;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// Bench for sprite_plotter: a pixel-list model checked every cycle plus directed literal checks.
module tb_sprite_plotter;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  x_in = '0;
  logic [6:0]  y_in = '0;
  logic [2:0]  colour_in = '0;
  logic [15:0] sprite_mask = '0;
  logic        erase_en = 1'b0;
  logic        busy, done, plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sprite_plotter #(
    .SPRITE_W(W), .SPRITE_H(H), .BG_COLOUR(3'b000), .SCREEN_W(160), .SCREEN_H(120)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
    .colour_in(colour_in), .sprite_mask(sprite_mask), .erase_en(erase_en),
    .busy(busy), .done(done), .x(x), .y(y), .colour(colour), .plot(plot)
  );

  // Model: each accepted start becomes a list of pixel cycles; k counts edges since the start edge.
  bit          m_active = 0;
  int          m_k = 0;
  int          m_P = 0;
  bit          m_pv = 0;
  int          m_px = 0, m_py = 0, m_nx = 0, m_ny = 0;
  logic [15:0] m_pm = '0, m_nm = '0;
  bit          e_plot [0:2*N-1];
  int          e_x [0:2*N-1];
  int          e_y [0:2*N-1];
  int          e_c [0:2*N-1];

  task automatic add_pix(input int px, input int py, input logic m, input int c);
    e_plot[m_P] = m && (px < 160) && (py < 120);
    e_x[m_P]    = px;
    e_y[m_P]    = py;
    e_c[m_P]    = c;
    m_P++;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 0;
      m_k      = 0;
      m_pv     = 0;
      m_px     = 0;
      m_py     = 0;
      m_pm     = '0;
    end else begin
      if (m_active) begin
        m_k++;
        if (m_k == m_P + 1) begin
          m_px = m_nx;
          m_py = m_ny;
          m_pm = m_nm;
          m_pv = 1;
        end
        if (m_k >= m_P + 2) m_active = 0;
      end
      if (!m_active && start) begin
        m_P = 0;
        if (erase_en && m_pv)
          for (int i = 0; i < N; i++) add_pix(m_px + i % W, m_py + i / W, m_pm[i], 0);
        for (int i = 0; i < N; i++)
          add_pix(int'(x_in) + i % W, int'(y_in) + i / W, sprite_mask[i], int'(colour_in));
        m_nx     = int'(x_in);
        m_ny     = int'(y_in);
        m_nm     = sprite_mask;
        m_active = 1;
        m_k      = 0;
      end
    end
  end

  bit eb, ed, ep;
  int ei;

  always @(negedge clk) begin
    eb = m_active;
    ed = m_active && (m_k == m_P + 1);
    ep = 0;
    ei = 0;
    if (m_active && m_k >= 1 && m_k <= m_P) begin
      ei = m_k - 1;
      ep = e_plot[ei];
    end
    n_cmp++;
    if (busy !== eb || done !== ed || plot !== ep) begin
      n_bad++;
      $display("FAIL ctrl t=%0t busy/done/plot got %b%b%b required %b%b%b",
               $time, busy, done, plot, eb, ed, ep);
    end
    if (ep && plot) begin
      n_cmp++;
      if (int'(x) != e_x[ei] || int'(y) != e_y[ei] || int'(colour) != e_c[ei]) begin
        n_bad++;
        $display("FAIL pixel t=%0t got (%0d,%0d,c%0d) required (%0d,%0d,c%0d)",
                 $time, x, y, colour, e_x[ei], e_y[ei], e_c[ei]);
      end
    end
  end

  int pq[$];

  function automatic int pk(input int px, input int py, input int c);
    return px * 65536 + py * 256 + c;
  endfunction

  function automatic int pget(input int i);
    return (i < pq.size()) ? pq[i] : -1;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic start_op(input int xi, input int yi, input int ci, input logic [15:0] m, input bit e);
    @(negedge clk);
    x_in        = 8'(xi);
    y_in        = 7'(yi);
    colour_in   = 3'(ci);
    sprite_mask = m;
    erase_en    = e;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    x_in        = 8'($urandom);
    y_in        = 7'($urandom);
    colour_in   = 3'($urandom);
    sprite_mask = 16'($urandom);
    erase_en    = 1'($urandom);
  endtask

  // Called at the negedge after the start edge; returns edges-to-done and the plotted pixels.
  task automatic wait_op(input int poke, input bit hold, output int k, output int np);
    int n;
    n  = 1;
    k  = -1;
    np = 0;
    pq.delete();
    while (n < 300) begin
      if (plot) begin
        np++;
        pq.push_back(pk(int'(x), int'(y), int'(colour)));
      end
      if (done) begin
        k = n - 1;
        break;
      end
      if (!hold) start = (n == poke);
      @(negedge clk);
      n++;
    end
    if (k < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got no done, required done within 300 cycles");
    end
  endtask

  int k, np;

  initial begin
    #1 reset = 1'b1;
    #3;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_plot", int'(plot), 0);
    chk("reset_xyc", pk(int'(x), int'(y), int'(colour)), 0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;

    start_op(10, 20, 4, 16'hFFFF, 1'b1);
    wait_op(0, 0, k, np);
    chk("first_done_edge", k, 17);
    chk("first_nplots", np, 16);
    chk("first_pix0", pget(0), pk(10, 20, 4));
    chk("first_pix15", pget(15), pk(13, 23, 4));

    start_op(11, 20, 4, 16'hFFFF, 1'b1);
    wait_op(0, 0, k, np);
    chk("move_done_edge", k, 33);
    chk("move_nplots", np, 32);
    chk("move_erase0", pget(0), pk(10, 20, 0));
    chk("move_erase15", pget(15), pk(13, 23, 0));
    chk("move_draw0", pget(16), pk(11, 20, 4));
    chk("move_draw15", pget(31), pk(14, 23, 4));

    start_op(158, 118, 1, 16'hFFFF, 1'b0);
    wait_op(0, 0, k, np);
    chk("clip_done_edge", k, 17);
    chk("clip_nplots", np, 4);
    chk("clip_pix0", pget(0), pk(158, 118, 1));
    chk("clip_pix1", pget(1), pk(159, 118, 1));
    chk("clip_pix2", pget(2), pk(158, 119, 1));
    chk("clip_pix3", pget(3), pk(159, 119, 1));

    start_op(50, 60, 2, 16'h0001, 1'b0);
    wait_op(0, 0, k, np);
    chk("mask_done_edge", k, 17);
    chk("mask_nplots", np, 1);
    chk("mask_pix0", pget(0), pk(50, 60, 2));

    start_op(70, 60, 2, 16'h0001, 1'b1);
    wait_op(20, 0, k, np);
    chk("poke_done_edge", k, 33);
    chk("poke_nplots", np, 2);
    chk("poke_erase", pget(0), pk(50, 60, 0));
    chk("poke_draw", pget(1), pk(70, 60, 2));
    @(negedge clk);
    chk("poke_done_once", int'(done), 0);
    chk("poke_idle", int'(busy), 0);

    @(negedge clk);
    x_in        = 8'd30;
    y_in        = 7'd40;
    colour_in   = 3'd7;
    sprite_mask = 16'hA5A5;
    erase_en    = 1'b1;
    start       = 1'b1;
    @(negedge clk);
    wait_op(0, 1, k, np);
    chk("hold_a_done_edge", k, 33);
    chk("hold_a_nplots", np, 9);
    chk("hold_a_erase", pget(0), pk(70, 60, 0));
    @(negedge clk);
    chk("hold_b_busy", int'(busy), 1);
    start = 1'b0;
    wait_op(0, 0, k, np);
    chk("hold_b_done_edge", k, 33);
    chk("hold_b_nplots", np, 16);
    chk("hold_b_erase0", pget(0), pk(30, 40, 0));
    chk("hold_b_draw0", pget(8), pk(30, 40, 7));

    start_op(0, 0, 5, 16'hFFFF, 1'b1);
    repeat (6) @(negedge clk);
    chk("abort_pre_plot", int'(plot), 1);
    chk("abort_pre_pix", pk(int'(x), int'(y), int'(colour)), pk(31, 41, 0));
    #2 reset = 1'b1;
    #1;
    chk("abort_plot", int'(plot), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    @(negedge clk);
    #2 reset = 1'b0;

    start_op(5, 5, 3, 16'hFFFF, 1'b1);
    wait_op(0, 0, k, np);
    chk("after_rst_done_edge", k, 17);
    chk("after_rst_nplots", np, 16);
    chk("after_rst_pix0", pget(0), pk(5, 5, 3));

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
